// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU operation sequencer.
// Used by alu_op_sequencer and its testbench.
package alu_seq_pkg;

  localparam int OP_W   = 3;
  localparam int OPND_W = 5;
  localparam int RES_W  = 10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HAVE_A = 3'd1,
    ST_EXEC   = 3'd2,
    ST_WAIT   = 3'd3,
    ST_SHOW   = 3'd4
  } seq_state_t;

  localparam logic [1:0] DISP_BLANK  = 2'd0;
  localparam logic [1:0] DISP_A      = 2'd1;
  localparam logic [1:0] DISP_AB     = 2'd2;
  localparam logic [1:0] DISP_RESULT = 2'd3;

  // Advance the operation code, wrapping after the last supported operation.
  function automatic logic [OP_W-1:0] next_op(input logic [OP_W-1:0] op,
                                              input int unsigned num_ops);
    if (32'(op) >= num_ops - 1) return '0;
    return op + 1'b1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button front-end: two-flop synchronizer, stability counter and one-shot
// press pulse. A level change is accepted only after DEBOUNCE_CYCLES stable samples.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic pulse
);

  localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_reg;
  logic             sync2_reg;
  logic             level_reg;
  logic             pulse_reg;
  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      level_reg <= 1'b0;
      pulse_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      sync1_reg <= raw;
      sync2_reg <= sync1_reg;
      pulse_reg <= 1'b0;
      if (sync2_reg == level_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_LAST) begin
        // Only the rising acceptance produces a pulse; release just re-arms.
        level_reg <= sync2_reg;
        cnt_reg   <= '0;
        pulse_reg <= sync2_reg;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign pulse = pulse_reg;

endmodule

// File: rtl/alu_op_sequencer.sv
// Front-end controller for the lab ALU: operand entry, op stepping, result latch.
// Optional build macro ALU_SEQ_AUTO_CYCLE_EN adds timed auto-advance in SHOW.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned NUM_OPS         = 8,
  parameter int unsigned ALU_LAT         = 1,
  parameter int unsigned AUTO_PERIOD     = 50000000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [OPND_W-1:0]         sw,
  input  logic                      btn_load,
  input  logic                      btn_next,
  input  logic [RES_W-1:0]          alu_result,
  output logic [2*OPND_W-1:0]       operands,
  output logic [OP_W-1:0]           op_sel,
  output logic [RES_W-1:0]          result,
  output logic                      result_valid,
  output logic [1:0]                disp_mode,
  output logic [2:0]                state_dbg
);

  // Reset asserts asynchronously everywhere but releases on a clock edge.
  logic rst_meta_reg;
  logic rst_sync_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_meta_reg <= 1'b0;
      rst_sync_n   <= 1'b0;
    end else begin
      rst_meta_reg <= 1'b1;
      rst_sync_n   <= rst_meta_reg;
    end
  end

  logic load_p;
  logic next_p;
  logic step_p;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load_db (
    .clk   (clk),
    .rst_n (rst_sync_n),
    .raw   (btn_load),
    .pulse (load_p)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next_db (
    .clk   (clk),
    .rst_n (rst_sync_n),
    .raw   (btn_next),
    .pulse (next_p)
  );

  seq_state_t        state_reg,  state_next;
  logic [OPND_W-1:0] opnd_a_reg, opnd_a_next;
  logic [OPND_W-1:0] opnd_b_reg, opnd_b_next;
  logic [OP_W-1:0]   op_reg,     op_next;
  logic [RES_W-1:0]  result_reg, result_next;
  logic              valid_reg,  valid_next;
  logic [3:0]        wait_reg,   wait_next;
  logic [1:0]        disp_next;

`ifdef ALU_SEQ_AUTO_CYCLE_EN
  localparam int unsigned       AUTO_W    = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
  localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_PERIOD - 1);

  logic [AUTO_W-1:0] auto_cnt_reg;
  logic              auto_hit;

  assign auto_hit = (state_reg == ST_SHOW) && (auto_cnt_reg == AUTO_LAST);

  // Interval restarts whenever SHOW is (re)entered or a button is pressed.
  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      auto_cnt_reg <= '0;
    end else if ((state_reg != ST_SHOW) || load_p || next_p || auto_hit) begin
      auto_cnt_reg <= '0;
    end else begin
      auto_cnt_reg <= auto_cnt_reg + 1'b1;
    end
  end

  assign step_p = next_p | auto_hit;
`else
  assign step_p = next_p;
`endif

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state_reg  <= ST_IDLE;
      opnd_a_reg <= '0;
      opnd_b_reg <= '0;
      op_reg     <= '0;
      result_reg <= '0;
      valid_reg  <= 1'b0;
      wait_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      opnd_a_reg <= opnd_a_next;
      opnd_b_reg <= opnd_b_next;
      op_reg     <= op_next;
      result_reg <= result_next;
      valid_reg  <= valid_next;
      wait_reg   <= wait_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    opnd_a_next = opnd_a_reg;
    opnd_b_next = opnd_b_reg;
    op_next     = op_reg;
    result_next = result_reg;
    valid_next  = valid_reg;
    wait_next   = wait_reg;
    disp_next   = DISP_BLANK;

    case (state_reg)
      ST_IDLE: begin
        disp_next = DISP_BLANK;
        if (load_p) begin
          opnd_a_next = sw;
          state_next  = ST_HAVE_A;
        end
      end
      ST_HAVE_A: begin
        disp_next = DISP_A;
        if (load_p) begin
          opnd_b_next = sw;
          valid_next  = 1'b0;
          state_next  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        disp_next  = DISP_AB;
        valid_next = 1'b0;
        wait_next  = 4'(ALU_LAT);
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        disp_next = DISP_AB;
        if (wait_reg == '0) begin
          result_next = alu_result;
          valid_next  = 1'b1;
          state_next  = ST_SHOW;
        end else begin
          wait_next = wait_reg - 1'b1;
        end
      end
      ST_SHOW: begin
        disp_next = DISP_RESULT;
        // LOAD beats NEXT when both arrive together.
        if (load_p) begin
          opnd_a_next = sw;
          opnd_b_next = '0;
          valid_next  = 1'b0;
          state_next  = ST_HAVE_A;
        end else if (step_p) begin
          op_next    = next_op(op_reg, NUM_OPS);
          valid_next = 1'b0;
          state_next = ST_EXEC;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign operands     = {opnd_a_reg, opnd_b_reg};
  assign op_sel       = op_reg;
  assign result       = result_reg;
  assign result_valid = valid_reg;
  assign disp_mode    = disp_next;
  assign state_dbg    = state_reg;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: per-cycle comparison against a
// timestamp-based behavioural model plus directed literal expectations.
module tb_alu_op_sequencer;

  localparam int DB    = 4;
  localparam int LAT   = 2;
  localparam int NOPS  = 8;
  localparam int AUTOP = 10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] sw;
  logic       btn_load;
  logic       btn_next;
  logic [9:0] alu_result;
  logic [9:0] operands;
  logic [2:0] op_sel;
  logic [9:0] result;
  logic       result_valid;
  logic [1:0] disp_mode;
  logic [2:0] state_dbg;

  alu_op_sequencer #(
    .DEBOUNCE_CYCLES (DB),
    .NUM_OPS         (NOPS),
    .ALU_LAT         (LAT),
    .AUTO_PERIOD     (AUTOP)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sw           (sw),
    .btn_load     (btn_load),
    .btn_next     (btn_next),
    .alu_result   (alu_result),
    .operands     (operands),
    .op_sel       (op_sel),
    .result       (result),
    .result_valid (result_valid),
    .disp_mode    (disp_mode),
    .state_dbg    (state_dbg)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Stand-in ALU: constant value or a value that changes every cycle.
  logic       alu_free  = 1'b0;
  logic [9:0] alu_const = 10'h2A5;
  int         cyc       = 0;

  always @(negedge clk) begin
    cyc++;
    alu_result = alu_free ? 10'((cyc * 37 + 5) % 1024) : alu_const;
  end

  // ---------------- behavioural model ----------------
  int         edge_n  = 0;
  int         rcnt    = 0;
  logic       hq_l[$];
  logic       hq_n[$];
  logic       acc_l   = 1'b0, acc_n  = 1'b0;
  logic       pend_l  = 1'b0, pend_n = 1'b0;
  int         m_state = 0;            // 0 idle, 1 have A, 2 busy, 4 show
  logic [4:0] m_a = '0, m_b = '0;
  logic [2:0] m_op    = '0;
  logic [9:0] m_res   = '0;
  logic       m_valid = 1'b0;
  int         m_start = 0;
  int         m_show  = 0;

  // True when the last DB synchronized samples (two edges old) all equal want.
  function automatic logic window_ok(input logic q[$], input logic want);
    if (q.size() < DB + 2) return 1'b0;
    for (int k = 0; k < DB; k++)
      if (q[q.size() - 3 - k] != want) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    logic lp, np, inr, auto_fire;
    edge_n++;
    inr  = !rst_n || (rcnt < 2);
    rcnt = !rst_n ? 0 : ((rcnt < 2) ? rcnt + 1 : 2);
    hq_l.push_back(inr ? 1'b0 : btn_load);
    hq_n.push_back(inr ? 1'b0 : btn_next);
    while (hq_l.size() > DB + 4) void'(hq_l.pop_front());
    while (hq_n.size() > DB + 4) void'(hq_n.pop_front());
    if (inr) begin
      acc_l = 1'b0; acc_n = 1'b0; pend_l = 1'b0; pend_n = 1'b0;
      m_state = 0; m_a = '0; m_b = '0; m_op = '0; m_res = '0; m_valid = 1'b0;
    end else begin
      lp = pend_l; np = pend_n; pend_l = 1'b0; pend_n = 1'b0;
      if (window_ok(hq_l, !acc_l)) begin acc_l = !acc_l; pend_l = acc_l; end
      if (window_ok(hq_n, !acc_n)) begin acc_n = !acc_n; pend_n = acc_n; end
      auto_fire = 1'b0;
`ifdef ALU_SEQ_AUTO_CYCLE_EN
      auto_fire = (m_state == 4) && !lp && !np && (edge_n - m_show == AUTOP);
`endif
      case (m_state)
        0: if (lp) begin m_a = sw; m_state = 1; end
        1: if (lp) begin m_b = sw; m_valid = 1'b0; m_state = 2; m_start = edge_n; end
        2: if (edge_n == m_start + LAT + 2) begin
             m_res = alu_result; m_valid = 1'b1; m_state = 4; m_show = edge_n;
           end
        4: if (lp) begin
             m_a = sw; m_b = '0; m_valid = 1'b0; m_state = 1;
           end else if (np || auto_fire) begin
             m_op = 3'((int'(m_op) + 1) % NOPS); m_valid = 1'b0; m_state = 2; m_start = edge_n;
           end
        default: m_state = 0;
      endcase
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    int exp_state, exp_disp;
    if (!rst_n) begin
      check("rst_operands", operands, 0);
      check("rst_op_sel", op_sel, 0);
      check("rst_result", result, 0);
      check("rst_valid", result_valid, 0);
      check("rst_disp", disp_mode, 0);
      check("rst_state", state_dbg, 0);
    end else begin
      case (m_state)
        0:       begin exp_state = 0; exp_disp = 0; end
        1:       begin exp_state = 1; exp_disp = 1; end
        2:       begin exp_state = (edge_n == m_start) ? 2 : 3; exp_disp = 2; end
        default: begin exp_state = 4; exp_disp = 3; end
      endcase
      check("m_operands", operands, {m_a, m_b});
      check("m_op_sel", op_sel, m_op);
      check("m_result", result, m_res);
      check("m_valid", result_valid, m_valid);
      check("m_disp", disp_mode, exp_disp);
      check("m_state", state_dbg, exp_state);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic press(input logic do_load, input logic do_next, input int hold);
    btn_load = do_load;
    btn_next = do_next;
    repeat (hold) @(negedge clk);
    btn_load = 1'b0;
    btn_next = 1'b0;
    repeat (DB + 4) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b1; sw = '0; btn_load = 1'b0; btn_next = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state", state_dbg, 0);
    check("reset_operands", operands, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Glitches shorter than the debounce window are rejected.
    repeat (3) begin
      btn_load = 1'b1; repeat (3) @(negedge clk);
      btn_load = 1'b0; repeat (3) @(negedge clk);
    end
    repeat (8) @(negedge clk);
    check("bounce_state", state_dbg, 0);
    check("bounce_disp", disp_mode, 0);

    // Operand A.
    sw = 5'b00011;
    press(1'b1, 1'b0, DB + 4);
    check("have_a_state", state_dbg, 1);
    check("have_a_disp", disp_mode, 1);
    check("have_a_operands", operands, 10'b00011_00000);

    // Operand B; result_valid rises 11 edges after the raw press.
    sw = 5'b11101;
    btn_load = 1'b1;
    repeat (10) @(negedge clk);
    check("lat_before_valid", result_valid, 0);
    check("lat_disp_ab", disp_mode, 2);
    @(negedge clk);
    check("lat_valid_rise", result_valid, 1);
    check("entry_operands", operands, 10'b00011_11101);
    check("entry_result", result, 10'h2A5);
    check("entry_disp", disp_mode, 3);
    btn_load = 1'b0;
    repeat (DB + 4) @(negedge clk);
    alu_free = 1'b1;

`ifndef ALU_SEQ_AUTO_CYCLE_EN
    repeat (7) press(1'b0, 1'b1, DB + 4);
    check("op_sel_7", op_sel, 7);
    begin
      int lowcount = 0;
      btn_next = 1'b1;
      for (int i = 0; i < 24; i++) begin
        @(negedge clk);
        if (i == 8) btn_next = 1'b0;
        if (result_valid == 1'b0) lowcount++;
      end
      check("wrap_op_sel", op_sel, 0);
      check("wrap_low_cycles", lowcount, LAT + 2);
    end
    sw = 5'b10110;
    press(1'b1, 1'b1, DB + 4);
    check("simul_state", state_dbg, 1);
    check("simul_operands", operands, 10'b10110_00000);
    check("simul_op_sel", op_sel, 0);
    check("simul_valid", result_valid, 0);
`else
    begin
      int t0 = -1, t1 = -1;
      logic [2:0] prev_op;
      prev_op = op_sel;
      for (int i = 0; i < 60; i++) begin
        @(negedge clk);
        if (op_sel != prev_op) begin
          if (t0 < 0) t0 = i;
          else if (t1 < 0) t1 = i;
          prev_op = op_sel;
        end
      end
      check("auto_interval", t1 - t0, AUTOP + LAT + 2);
    end
`endif

    // Reset asserted while waiting on the ALU.
    sw = 5'b01010;
    btn_load = 1'b1;
    repeat (8) @(negedge clk);
`ifndef ALU_SEQ_AUTO_CYCLE_EN
    check("pre_reset_wait", state_dbg, 3);
`endif
    #2 rst_n = 1'b0;
    #1;
    check("async_state", state_dbg, 0);
    check("async_valid", result_valid, 0);
    check("async_operands", operands, 0);
    check("async_op_sel", op_sel, 0);
    check("async_result", result, 0);
    check("async_disp", disp_mode, 0);
    btn_load = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("post_reset_valid", result_valid, 0);
    check("post_reset_state", state_dbg, 0);

    // Fresh entry with a moving ALU result.
    sw = 5'b10000;
    press(1'b1, 1'b0, DB + 4);
    sw = 5'b01111;
    press(1'b1, 1'b0, DB + 4);
    check("reentry_valid", result_valid, 1);
    check("reentry_operands", operands, 10'b10000_01111);
    repeat (5) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Front-end controller for the lab ALU datapath and its six-digit sign/tens/ones operand display.
- Captures two 5-bit two's-complement operands from one switch bank using a debounced LOAD button.
- Drives the operation code to the ALU and waits a fixed latency, then latches the result.
- Steps through operations on a debounced NEXT button and tells the display mux what to show.

Parameters:
- DEBOUNCE_CYCLES, 250000: cycles a raw button must be stable before it is accepted (5 ms at 50 MHz).
- NUM_OPS, 8: number of ALU operations; op_sel wraps at NUM_OPS-1.
- ALU_LAT, 1: clock cycles from a stable op_sel/operands to a valid alu_result (1..15).
- AUTO_PERIOD, 50000000: auto-advance interval in cycles; used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- sw  in  5  operand switches, two's complement
- btn_load  in  1  raw, asynchronous LOAD button, active-high
- btn_next  in  1  raw, asynchronous NEXT button, active-high
- alu_result  in  10  result from the ALU datapath
- operands  out  10  {A, B} to the ALU and operand display; A in [9:5], B in [4:0]
- op_sel  out  3  ALU operation code
- result  out  10  latched ALU result
- result_valid  out  1  result reflects the current operands and op_sel
- disp_mode  out  2  display source: 0 = blank, 1 = operand A only, 2 = both operands, 3 = result
- state_dbg  out  3  encoded FSM state

Behaviour:
- Reset (async assert, sync release via two-flop synchronizer on rst_n deassert):
  - operands = 0, op_sel = 0, result = 0, result_valid = 0, disp_mode = 0, state = IDLE.
  - Debounce counters cleared.
- Button front-end:
  - Each raw button is double-flopped, then debounced.
  - A press yields exactly one clk-wide pulse (load_p / next_p) when the level has been stable high for DEBOUNCE_CYCLES.
  - No new pulse until the button has been stable low for DEBOUNCE_CYCLES.
- FSM states: IDLE(0), HAVE_A(1), EXEC(2), WAIT(3), SHOW(4).
  - IDLE: on load_p, operands[9:5] <= sw and go to HAVE_A; disp_mode = 1.
  - HAVE_A: on load_p, operands[4:0] <= sw and go to EXEC; disp_mode = 2.
  - EXEC: one cycle. result_valid <= 0, wait counter <= ALU_LAT, go to WAIT.
  - WAIT: decrement the counter. At 0, result <= alu_result, result_valid <= 1, go to SHOW; disp_mode = 3.
  - SHOW:
    - next_p: op_sel <= (op_sel == NUM_OPS-1) ? 0 : op_sel+1, then go to EXEC.
    - load_p: operands[9:5] <= sw, operands[4:0] <= 0, result_valid <= 0, op_sel held, go to HAVE_A.
- Latency: result_valid rises ALU_LAT+2 cycles after the accepting pulse.
- Ignored pulses: next_p is ignored in IDLE and HAVE_A; load_p and next_p are ignored in EXEC and WAIT.
- Simultaneous load_p and next_p in SHOW: load wins.
- operands and op_sel are stable for the whole of EXEC/WAIT; never change while result_valid = 0 mid-computation.
- result holds its value outside WAIT-completion; result_valid clears on EXEC entry.
- Reset mid-WAIT: immediate async clear; any partial wait is discarded.
- Widths: operands and result pass through with no sign extension or arithmetic in this block.

Optional Feature:
- Macro: ALU_SEQ_AUTO_CYCLE_EN.
- When defined: in SHOW, a free counter reaching AUTO_PERIOD-1 acts as next_p (same wrap rules).
  - The counter resets on SHOW entry and on any button pulse.
  - A real next_p or load_p in the same cycle takes priority.
- When undefined: counter logic is absent; SHOW waits only on buttons.

Decomposition:
- Package alu_seq_pkg: FSM state enum (3-bit), DISP_* constants for disp_mode, OP_W = 3, OPND_W = 5, RES_W = 10.
- One sub-module, btn_debounce (synchronizer + stability counter + one-shot pulse), instantiated twice.

Test Plan:
- Reset with rst_n low mid-WAIT -> all outputs 0, state_dbg = 0 immediately (async), no result_valid after release.
- Entry: sw = 5'b00011 + load, then sw = 5'b11101 + load (DEBOUNCE_CYCLES = 4 in bench) -> operands = 10'b00011_11101, disp_mode 1 then 2, result_valid = 1 exactly ALU_LAT+2 cycles after the second pulse, result = alu_result.
- Bounce rejection: 3-cycle glitches on btn_load with DEBOUNCE_CYCLES = 4 -> no state change; a held press -> exactly one pulse.
- Wrap: in SHOW with op_sel = 7, NUM_OPS = 8, press next -> op_sel = 0, result_valid drops for ALU_LAT+2 cycles, then rises.
- Simultaneous load_p and next_p in SHOW -> HAVE_A, operands[9:5] = sw, op_sel unchanged.
- With ALU_SEQ_AUTO_CYCLE_EN and AUTO_PERIOD = 10 -> op_sel increments every 10+ALU_LAT+2 cycles while idle in SHOW; a next press restarts the interval.
